// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/issue slice: FSM state encoding,
// reset PC and bubble word defaults, and the prefetch FIFO entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'hBFC00000;
  localparam logic [31:0] FETCH_NOP      = 32'h00000000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_issue_unit_fifo.sv
// Prefetch FIFO (module fetch_fifo): DEPTH entries of {instr, pc}, with
// synchronous clear, simultaneous push/pop, and head/count/full/empty views.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear wins over any push/pop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is left unreset.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch/issue unit: single-outstanding instruction fetch into a prefetch
// FIFO, issuing one instruction per cycle toward IF/ID with STALL/FLUSH.
// Optional macro FETCH_PERF_EN adds saturating Bubble_Count/Flush_Count.
module fetch_issue_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = FETCH_NOP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Data,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] Bubble_Count,
  output logic [31:0] Flush_Count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_state_t state_q, state_d;
  logic         req_d;
  logic [31:0]  addr_d;
  logic [31:0]  pc_q, pc_d;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;

  logic         vld_p1;
  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;

  assign push_entry = '{instr: Mem_Data, pc: pc_q};
  assign pop        = !FLUSH && !STALL && !fifo_empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .pop       (pop),
    .clear     (FLUSH),
    .push_data (push_entry),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request FSM: one outstanding request; a flushed request is still waited
  // out in DISCARD so its late ack cannot be mistaken for a new fetch.
  always_comb begin
    state_d = state_q;
    req_d   = Mem_Req;
    addr_d  = Mem_Addr;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (FLUSH) begin
          pc_d = FLUSH_PC;
        end else if (fifo_count < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (FLUSH) begin
          pc_d = FLUSH_PC;
          if (Mem_Ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (Mem_Ack) begin
          push    = !fifo_full;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (FLUSH) pc_d = FLUSH_PC;
        if (Mem_Ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and registered memory request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      Mem_Req  <= 1'b0;
      Mem_Addr <= '0;
      pc_q     <= RESET_PC;
    end else begin
      state_q  <= state_d;
      Mem_Req  <= req_d;
      Mem_Addr <= addr_d;
      pc_q     <= pc_d;
    end
  end

  // ---- issue stage p1: FLUSH forces a bubble, STALL holds, else pop head ----
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (FLUSH) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_WORD;
      pc_p1    <= '0;
    end else if (!STALL) begin
      if (!fifo_empty) begin
        vld_p1   <= 1'b1;
        instr_p1 <= head.instr;
        pc_p1    <= head.pc;
      end else begin
        vld_p1   <= 1'b0;
        instr_p1 <= NOP_WORD;
        pc_p1    <= '0;
      end
    end
  end

  // PC+4 is derived from the issued PC; a valid PC of 0 still yields 4.
  assign Instr1_OUT     = instr_p1;
  assign Instr_PC_OUT   = pc_p1;
  assign Instr_PC_Plus4 = vld_p1 ? (pc_p1 + 32'd4) : 32'd0;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating event counters for bubbles issued and flush cycles.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Bubble_Count <= '0;
      Flush_Count  <= '0;
    end else begin
      if (!STALL && !FLUSH && fifo_empty) Bubble_Count <= sat_inc(Bubble_Count);
      if (FLUSH) Flush_Count <= sat_inc(Flush_Count);
    end
  end
`else
  // Build without performance counters: no extra state.
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed self-checking bench for fetch_issue_unit (default build).
module tb_fetch_issue_unit;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_Data;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4;

  int vectors = 0;
  int errors  = 0;
  logic auto_ack;

  fetch_issue_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .STALL          (STALL),
    .FLUSH          (FLUSH),
    .FLUSH_PC       (FLUSH_PC),
    .Mem_Req        (Mem_Req),
    .Mem_Addr       (Mem_Addr),
    .Mem_Ack        (Mem_Ack),
    .Mem_Data       (Mem_Data),
    .Instr1_OUT     (Instr1_OUT),
    .Instr_PC_OUT   (Instr_PC_OUT),
    .Instr_PC_Plus4 (Instr_PC_Plus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: every word is its address XOR a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Zero-wait memory: acknowledge whatever request is currently visible.
  task automatic mem_drive();
    Mem_Ack  = Mem_Req;
    Mem_Data = Mem_Req ? mem_word(Mem_Addr) : 32'h0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (auto_ack) mem_drive();
  endtask

  task automatic do_reset();
    RESET    = 1'b0;
    STALL    = 1'b0;
    FLUSH    = 1'b0;
    FLUSH_PC = 32'h0;
    Mem_Ack  = 1'b0;
    Mem_Data = 32'h0;
    auto_ack = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET    = 1'b0;
    STALL    = 1'b0;
    FLUSH    = 1'b0;
    FLUSH_PC = 32'h0;
    Mem_Ack  = 1'b0;
    Mem_Data = 32'h0;
    auto_ack = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !== 129'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h instr=%h pc=%h p4=%h, want all 0",
               Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4);
    end
    RESET = 1'b1;
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr} !== {1'b1, 32'hBFC00000}) begin
      errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=bfc00000", Mem_Req, Mem_Addr);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C};
    do_reset();
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr} !== {1'b1, 32'hBFC00000}) begin
      errors++;
      $display("FAIL seq_req0: got req=%b addr=%h, want 1 bfc00000", Mem_Req, Mem_Addr);
    end
    step();
    vectors++;
    if ({Mem_Req, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !== {1'b0, 96'h0}) begin
      errors++;
      $display("FAIL seq_bubble0: got req=%b instr=%h pc=%h p4=%h, want 0 0 0 0",
               Mem_Req, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Mem_Req, Mem_Addr} !==
          {mem_word(exp_pc[k]), exp_pc[k], exp_pc[k] + 32'd4, 1'b1, exp_pc[k] + 32'd4}) begin
        errors++;
        $display("FAIL seq_issue[%0d]: got instr=%h pc=%h p4=%h req=%b addr=%h, want instr=%h pc=%h p4=%h req=1 addr=%h",
                 k, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Mem_Req, Mem_Addr,
                 mem_word(exp_pc[k]), exp_pc[k], exp_pc[k] + 32'd4, exp_pc[k] + 32'd4);
      end
      step();
      vectors++;
      if ({Instr_PC_OUT, Instr_PC_Plus4} !== 64'h0) begin
        errors++;
        $display("FAIL seq_gap[%0d]: got pc=%h p4=%h, want 0 0", k, Instr_PC_OUT, Instr_PC_Plus4);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    int acks;
    exp_pc = '{32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010};
    do_reset();
    repeat (3) step();
    STALL = 1'b1;
    acks  = 0;
    for (int i = 0; i < 9; i++) begin
      if (Mem_Ack) acks++;
      step();
      vectors++;
      if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !==
          {mem_word(32'hBFC00000), 32'hBFC00000, 32'hBFC00004}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got instr=%h pc=%h p4=%h, want instr=%h pc=bfc00000 p4=bfc00004",
                 i, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, mem_word(32'hBFC00000));
      end
    end
    vectors++;
    if (acks !== 4) begin
      errors++;
      $display("FAIL stall_acks: got %0d accepted, want 4", acks);
    end
    vectors++;
    if (Mem_Req !== 1'b0) begin
      errors++;
      $display("FAIL stall_full_noreq: got req=%b, want 0", Mem_Req);
    end
    STALL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !==
          {mem_word(exp_pc[k]), exp_pc[k], exp_pc[k] + 32'd4}) begin
        errors++;
        $display("FAIL stall_drain[%0d]: got instr=%h pc=%h p4=%h, want instr=%h pc=%h",
                 k, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, mem_word(exp_pc[k]), exp_pc[k]);
      end
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    auto_ack = 1'b0;
    step();
    FLUSH    = 1'b1;
    FLUSH_PC = 32'h00400020;
    step();
    FLUSH = 1'b0;
    vectors++;
    if ({Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !==
        {1'b1, 32'hBFC00000, 96'h0}) begin
      errors++;
      $display("FAIL flush_discard: got req=%b addr=%h instr=%h pc=%h p4=%h, want 1 bfc00000 0 0 0",
               Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4);
    end
    step();
    Mem_Ack  = 1'b1;
    Mem_Data = 32'hDEADBEEF;
    step();
    Mem_Ack  = 1'b0;
    Mem_Data = 32'h0;
    vectors++;
    if ({Mem_Req, Instr1_OUT, Instr_PC_OUT} !== {1'b0, 64'h0}) begin
      errors++;
      $display("FAIL flush_late_ack: got req=%b instr=%h pc=%h, want 0 0 0", Mem_Req, Instr1_OUT, Instr_PC_OUT);
    end
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr} !== {1'b1, 32'h00400020}) begin
      errors++;
      $display("FAIL flush_new_req: got req=%b addr=%h, want 1 00400020", Mem_Req, Mem_Addr);
    end
    auto_ack = 1'b1;
    mem_drive();
    step();
    step();
    vectors++;
    if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !==
        {mem_word(32'h00400020), 32'h00400020, 32'h00400024}) begin
      errors++;
      $display("FAIL flush_redirect_issue: got instr=%h pc=%h p4=%h, want %h 00400020 00400024",
               Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, mem_word(32'h00400020));
    end
  endtask

  task automatic test_flush_ack_stall();
    do_reset();
    repeat (3) step();
    vectors++;
    if ({Instr_PC_OUT, Mem_Req, Mem_Addr} !== {32'hBFC00000, 1'b1, 32'hBFC00004}) begin
      errors++;
      $display("FAIL fas_setup: got pc=%h req=%b addr=%h, want bfc00000 1 bfc00004", Instr_PC_OUT, Mem_Req, Mem_Addr);
    end
    auto_ack = 1'b0;
    STALL    = 1'b1;
    FLUSH    = 1'b1;
    FLUSH_PC = 32'h00400040;
    Mem_Ack  = 1'b1;
    Mem_Data = 32'hDEADBEEF;
    step();
    FLUSH    = 1'b0;
    Mem_Ack  = 1'b0;
    Mem_Data = 32'h0;
    vectors++;
    if ({Mem_Req, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !== {1'b0, 96'h0}) begin
      errors++;
      $display("FAIL fas_bubble: got req=%b instr=%h pc=%h p4=%h, want 0 0 0 0",
               Mem_Req, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4);
    end
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT} !== {1'b1, 32'h00400040, 64'h0}) begin
      errors++;
      $display("FAIL fas_idle_req: got req=%b addr=%h instr=%h pc=%h, want 1 00400040 0 0",
               Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT);
    end
    STALL    = 1'b0;
    auto_ack = 1'b1;
    mem_drive();
    step();
    step();
    vectors++;
    if ({Instr1_OUT, Instr_PC_OUT} !== {mem_word(32'h00400040), 32'h00400040}) begin
      errors++;
      $display("FAIL fas_issue: got instr=%h pc=%h, want %h 00400040", Instr1_OUT, Instr_PC_OUT, mem_word(32'h00400040));
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    FLUSH    = 1'b1;
    FLUSH_PC = 32'hFFFFFFFC;
    step();
    FLUSH = 1'b0;
    vectors++;
    if (Mem_Req !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flush_noreq: got req=%b, want 0", Mem_Req);
    end
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr} !== {1'b1, 32'hFFFFFFFC}) begin
      errors++;
      $display("FAIL wrap_req: got req=%b addr=%h, want 1 fffffffc", Mem_Req, Mem_Addr);
    end
    step();
    step();
    vectors++;
    if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Mem_Req, Mem_Addr} !==
        {mem_word(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_issue: got instr=%h pc=%h p4=%h req=%b addr=%h, want %h fffffffc 0 1 0",
               Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Mem_Req, Mem_Addr, mem_word(32'hFFFFFFFC));
    end
    step();
    step();
    vectors++;
    if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !== {mem_word(32'h0), 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL wrap_pc0: got instr=%h pc=%h p4=%h, want %h 0 4",
               Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, mem_word(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) step();
    auto_ack = 1'b0;
    Mem_Ack  = 1'b0;
    Mem_Data = 32'h0;
    vectors++;
    if ({Mem_Req, Instr_PC_OUT} !== {1'b1, 32'hBFC00000}) begin
      errors++;
      $display("FAIL areset_pre: got req=%b pc=%h, want 1 bfc00000", Mem_Req, Instr_PC_OUT);
    end
    #2;
    RESET = 1'b0;
    #1;
    vectors++;
    if ({Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} !== 129'h0) begin
      errors++;
      $display("FAIL areset_immediate: got req=%b addr=%h instr=%h pc=%h p4=%h, want all 0",
               Mem_Req, Mem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4);
    end
    @(posedge CLK);
    #1;
    RESET    = 1'b1;
    auto_ack = 1'b1;
    step();
    vectors++;
    if ({Mem_Req, Mem_Addr} !== {1'b1, 32'hBFC00000}) begin
      errors++;
      $display("FAIL areset_restart: got req=%b addr=%h, want 1 bfc00000", Mem_Req, Mem_Addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_flush_wait();
    test_flush_ack_stall();
    test_pc_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
